bsg_adder_accumulator: RTL

//  Packet accumulator built on the 16-bit ripple-carry adder. Consumes a valid/ready

---
 rtl/bsg_adder_accumulator_pkg.sv | 13 +
 rtl/bsg_adder_accumulator_if.sv | 36 +++
 rtl/bsg_adder_accumulator_adder.sv | 24 ++
 rtl/bsg_adder_accumulator.sv | 96 +++++++++
 4 files changed

// File: rtl/bsg_adder_accumulator_pkg.sv
// Shared types for the packet accumulator: FSM state encoding and the
// width of the ripple-carry adder used for the low accumulator bits.
package bsg_adder_accum_pkg;

   // eACCUM: taking words into the running sum; eDONE: holding a finished sum
   typedef enum logic [0:0] {
      eACCUM = 1'b0,
      eDONE  = 1'b1
   } state_e;

   localparam int adder_width_lp = 16;

endpackage

// File: rtl/bsg_adder_accumulator_if.sv
// Stream-in / sum-out bundle of the packet accumulator.
//
// Handshake rules:
//   input side : a word transfers on a rising clk_i edge where v_i & ready_o;
//                last_i is only meaningful together with v_i.
//   output side: sum_o/items_o are valid while v_o=1 and stay stable until a
//                rising edge with yumi_i=1; yumi_i may only be raised while v_o=1.
interface bsg_adder_accumulator_if #(
   parameter int width_p = 16,
   parameter int els_p   = 8
);
   localparam int lg_els_lp = $clog2(els_p);
   localparam int cnt_w_lp  = $clog2(els_p + 1);

   logic [width_p-1:0]           data_i;
   logic                         v_i;
   logic                         last_i;
   logic                         ready_o;
   logic [width_p+lg_els_lp-1:0] sum_o;
   logic [cnt_w_lp-1:0]          items_o;
   logic                         v_o;
   logic                         yumi_i;

   // Producer/consumer side
   modport master (
      output data_i, v_i, last_i, yumi_i,
      input  ready_o, sum_o, items_o, v_o
   );

   // Accumulator side
   modport slave (
      input  data_i, v_i, last_i, yumi_i,
      output ready_o, sum_o, items_o, v_o
   );

endinterface

// File: rtl/bsg_adder_accumulator_adder.sv
// Plain ripple-carry adder: carry-in tied to zero, carry-out exported so the
// accumulator can extend its sum above width_p bits.
module bsg_adder_ripple_carry #(
   parameter int width_p = 16
) (
   input  logic [width_p-1:0] a_i,
   input  logic [width_p-1:0] b_i,
   output logic [width_p-1:0] s_o,
   output logic               c_o
);

   logic [width_p:0] carry;

   assign carry[0] = 1'b0;

   // One full adder per bit, carry rippling from bit 0 upward
   for (genvar i = 0; i < width_p; i++) begin : g_bit
      assign s_o[i]       = a_i[i] ^ b_i[i] ^ carry[i];
      assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
   end

   assign c_o = carry[width_p];

endmodule

// File: rtl/bsg_adder_accumulator.sv
// Packet accumulator. Each accepted word is added to a running sum; the adder
// produces the low width_p bits and its carry-out bumps a small upper counter.
// A packet closes on last_i or on its els_p-th word, after which the sum is
// held on the output until the consumer yumis it.
module bsg_adder_accumulator
   import bsg_adder_accum_pkg::*;
#(
   parameter int width_p = 16,
   parameter int els_p   = 8
) (
   input  logic                          clk_i,
   input  logic                          reset_n_i,
   bsg_adder_accumulator_if.slave        bus,
   output state_e                        state_o
);

   localparam int lg_els_lp = $clog2(els_p);
   localparam int cnt_w_lp  = $clog2(els_p + 1);

   state_e                 state_r, state_n;
   logic [width_p-1:0]     acc_lo_r;
   logic [lg_els_lp-1:0]   acc_hi_r;
   logic [cnt_w_lp-1:0]    count_r;

   logic                   ready;
   logic                   accept;
   logic                   first_word;
   logic                   close_pkt;
   logic [width_p-1:0]     adder_a;
   logic [width_p-1:0]     adder_s;
   logic                   adder_c;
   logic [lg_els_lp-1:0]   hi_base;
   logic [lg_els_lp-1:0]   hi_next;
   logic [cnt_w_lp-1:0]    count_inc;

   assign ready      = (state_r == eACCUM);
   assign accept     = bus.v_i & ready;
   // count==0 marks the first word of a packet: the old sum is dropped by
   // feeding zero into the adder, so no separate clear cycle is needed
   assign first_word = (count_r == '0);
   assign adder_a    = first_word ? '0 : acc_lo_r;
   assign hi_base    = first_word ? '0 : acc_hi_r;
   assign hi_next    = hi_base + lg_els_lp'(adder_c);
   assign count_inc  = count_r + cnt_w_lp'(1);
   assign close_pkt  = bus.last_i | (count_inc == cnt_w_lp'(els_p));

   bsg_adder_ripple_carry #(
      .width_p (width_p)
   ) adder (
      .a_i (adder_a),
      .b_i (bus.data_i),
      .s_o (adder_s),
      .c_o (adder_c)
   );

   // State register
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r <= eACCUM;
      end else begin
         state_r <= state_n;
      end
   end

   // Next-state: close the packet on its final accepted word, reopen on yumi
   always_comb begin
      state_n = state_r;
      case (state_r)
         eACCUM: if (accept && close_pkt) state_n = eDONE;
         eDONE:  if (bus.yumi_i)          state_n = eACCUM;
         default: state_n = eACCUM;
      endcase
   end

   // Accumulator and item counter; the count is cleared when the sum is taken
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         acc_lo_r <= '0;
         acc_hi_r <= '0;
         count_r  <= '0;
      end else if (accept) begin
         acc_lo_r <= adder_s;
         acc_hi_r <= hi_next;
         count_r  <= count_inc;
      end else if ((state_r == eDONE) && bus.yumi_i) begin
         count_r  <= '0;
      end
   end

   assign bus.ready_o = ready;
   assign bus.v_o     = (state_r == eDONE);
   assign bus.sum_o   = {acc_hi_r, acc_lo_r};
   assign bus.items_o = count_r;
   assign state_o     = state_r;

endmodule
